alu_uart_sequencer: RTL
=======================

Name: alu_uart_sequencer

Overview:
- Sequences the UART-to-ALU-to-UART datapath.
- Pops three bytes from the RX FIFO (operand A, operand B, opcode), presents them to the combinational ALU, latches the result, then hands it to the Int_Tx block via a one-cycle `enviar` pulse with `DATO_ALU`.
- Sits between the RX FIFO, the ALU and Int_Tx. It is the only block that drives ALU operands and the Int_Tx request.

Parameters:
- DBIT, 8, data width of FIFO bytes, ALU operands and result.
- OPBITS, 6, opcode width; taken from the low OPBITS bits of the third byte.
- TIMEOUT_CYCLES, 1000, stall limit used only when SEQ_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- rx_empty  input  1  RX FIFO empty flag.
- rx_data  input  DBIT  RX FIFO head word; first-word-fall-through, valid whenever rx_empty=0.
- RD_FIFO  output  1  RX FIFO pop strobe, one cycle per byte.
- alu_a  output  DBIT  registered operand A to the ALU.
- alu_b  output  DBIT  registered operand B to the ALU.
- alu_op  output  OPBITS  registered opcode to the ALU.
- alu_result  input  DBIT  combinational ALU result.
- tx_full  input  1  from Int_Tx `fifo_full`; blocks the send.
- enviar  output  1  one-cycle send request to Int_Tx.
- DATO_ALU  output  DBIT  registered result presented to Int_Tx.
- op_count  output  8  count of completed operations.
- state_dbg  output  3  current state encoding, for the bench.
- seq_err  output  1  timeout abort pulse; constant 0 unless SEQ_TIMEOUT_EN is defined.

Behaviour:
- Reset is synchronous and active-high: on a rising CLK edge with RESET=1, the block goes to state GET_A.
  - Output reset values: alu_a, alu_b, alu_op, DATO_ALU, op_count = 0; RD_FIFO, enviar, seq_err = 0.
  - RESET overrides any in-progress frame; partial bytes are discarded and the next popped byte is A.
- States and encoding: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SEND=4.
- GET_A / GET_B / GET_OP:
  - While rx_empty=1: RD_FIFO=0, hold state.
  - While rx_empty=0: RD_FIFO=1 combinationally in that cycle. On the edge, rx_data is captured into alu_a, alu_b, or alu_op (low OPBITS bits) respectively, and the state advances.
  - Exactly one pop per state visit. RD_FIFO is never asserted while rx_empty=1 or outside these states.
- EXEC: always lasts one cycle, which lets the ALU settle on the registered operands. DATO_ALU <= alu_result on the edge; then go to SEND.
- SEND:
  - enviar = ~tx_full, combinational.
  - If tx_full=0: enviar=1 for this single cycle, op_count increments (wraps 255 to 0), next state GET_A.
  - If tx_full=1: enviar=0, hold SEND with DATO_ALU stable until tx_full drops.
- Latency: the opcode pop happens at edge c. EXEC occupies cycle c+1. enviar is high in cycle c+2 if tx_full=0.
  - Minimum frame is 5 cycles from A pop to enviar with a non-empty FIFO.
  - With back-to-back data, the next A pop occurs in the cycle after enviar.
- Operand hold: alu_a, alu_b and alu_op hold their values until overwritten by the next frame. DATO_ALU holds until the next EXEC.
- Simultaneous events: rx_empty is ignored in EXEC and SEND. A byte arriving while in SEND waits in the FIFO.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A stall counter counts cycles spent waiting in GET_B or GET_OP with rx_empty=1. It is cleared on every pop and in GET_A.
  - When the counter reaches TIMEOUT_CYCLES, the block aborts to GET_A and seq_err=1 for one cycle. alu_a, alu_b and alu_op are not cleared, and op_count is unchanged.
  - SEND never times out.
- Not defined: no counter is built, seq_err is tied to 0, and the block waits in any state indefinitely.

Test Plan:
- FIFO pre-loaded with 0x05, 0x03, 0x20 and ALU model ADD for 0x20 -> three one-cycle RD_FIFO pulses, alu_a=5, alu_b=3, alu_op=0x20. enviar pulses exactly 2 cycles after the third pop with DATO_ALU=0x08; op_count=1.
- Same frame with tx_full=1 held for 10 cycles starting at EXEC -> enviar stays 0 and state_dbg=4 for 10 cycles, DATO_ALU steady at 0x08. One enviar pulse occurs in the first cycle tx_full=0.
- Bytes 0x4B, then rx_empty=1 for 20 cycles, then 0x02 and 0x22 (SUB) -> no extra RD_FIFO pulses during the gap; DATO_ALU=0x49 and one enviar pulse.
- RESET asserted for 1 cycle after A=0x11 and B=0x22 are popped, then bytes 0x01, 0x01, 0x20 -> outputs zeroed on the reset edge. The new frame yields DATO_ALU=0x02; op_count=1, not counting the aborted frame.
- 256 back-to-back frames -> op_count wraps to 0. No gap cycles beyond the 5-cycle frame when the FIFO is non-empty and tx_full=0.
- SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, pop A=0x07 then rx_empty=1 -> seq_err=1 for one cycle and state_dbg=0. The next byte 0x09 is taken as A, and op_count is unchanged.

Source files
------------

// File: rtl/alu_uart_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_uart_sequencer_if
// Purpose : Bundles RX FIFO, ALU and Int_Tx signals around the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_uart_sequencer_if #(
  parameter int DBIT   = 8,
  parameter int OPBITS = 6
);
  logic              rx_empty;
  logic [DBIT-1:0]   rx_data;
  logic              RD_FIFO;
  logic [DBIT-1:0]   alu_a;
  logic [DBIT-1:0]   alu_b;
  logic [OPBITS-1:0] alu_op;
  logic [DBIT-1:0]   alu_result;
  logic              tx_full;
  logic              enviar;
  logic [DBIT-1:0]   DATO_ALU;
  logic [7:0]        op_count;
  logic [2:0]        state_dbg;
  logic              seq_err;

  modport master (
    input  rx_empty, rx_data, alu_result, tx_full,
    output RD_FIFO, alu_a, alu_b, alu_op, enviar, DATO_ALU, op_count, state_dbg, seq_err
  );

  modport slave (
    output rx_empty, rx_data, alu_result, tx_full,
    input  RD_FIFO, alu_a, alu_b, alu_op, enviar, DATO_ALU, op_count, state_dbg, seq_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_uart_sequencer
// Purpose : Pops A, B, opcode from the RX FIFO, runs the ALU, sends the result
//           to Int_Tx. Optional stall timeout enabled by macro SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_uart_sequencer #(
  parameter int DBIT           = 8,
  parameter int OPBITS         = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input wire CLK,
  input wire RESET,
  alu_uart_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DBIT-1:0]   alu_a_q, alu_a_d;
  logic [DBIT-1:0]   alu_b_q, alu_b_d;
  logic [OPBITS-1:0] alu_op_q, alu_op_d;
  logic [DBIT-1:0]   dato_q, dato_d;
  logic [7:0]        op_count_q, op_count_d;
  logic              rd_fifo;
  logic              enviar;

`ifdef SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               seq_err_q, seq_err_d;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= GET_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      dato_q     <= '0;
      op_count_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      stall_q    <= '0;
      seq_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      dato_q     <= dato_d;
      op_count_q <= op_count_d;
`ifdef SEQ_TIMEOUT_EN
      stall_q    <= stall_d;
      seq_err_q  <= seq_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    dato_d     = dato_q;
    op_count_d = op_count_q;
    rd_fifo    = 1'b0;
    enviar     = 1'b0;

    case (state_q)
      GET_A: begin
        if (!bus.rx_empty) begin
          rd_fifo = 1'b1;
          alu_a_d = bus.rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (!bus.rx_empty) begin
          rd_fifo = 1'b1;
          alu_b_d = bus.rx_data;
          state_d = GET_OP;
        end
      end
      GET_OP: begin
        if (!bus.rx_empty) begin
          rd_fifo  = 1'b1;
          alu_op_d = bus.rx_data[OPBITS-1:0];
          state_d  = EXEC;
        end
      end
      // One settle cycle for the combinational ALU on the registered operands.
      EXEC: begin
        dato_d  = bus.alu_result;
        state_d = SEND;
      end
      SEND: begin
        if (!bus.tx_full) begin
          enviar     = 1'b1;
          op_count_d = op_count_q + 8'd1;
          state_d    = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase

`ifdef SEQ_TIMEOUT_EN
    stall_d   = '0;
    seq_err_d = 1'b0;
    // Only a starved mid-frame wait can time out; a pop or leaving restarts it.
    if ((state_q == GET_B || state_q == GET_OP) && bus.rx_empty) begin
      if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = GET_A;
        seq_err_d = 1'b1;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
`endif
  end

  assign bus.RD_FIFO   = rd_fifo;
  assign bus.enviar    = enviar;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.DATO_ALU  = dato_q;
  assign bus.op_count  = op_count_q;
  assign bus.state_dbg = state_q;

`ifdef SEQ_TIMEOUT_EN
  assign bus.seq_err = seq_err_q;
`else
  // No timeout hardware; the term is constant 0 and only keeps the parameter referenced.
  assign bus.seq_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule
`default_nettype wire
